// File: rtl/fp_normalize.sv
// fp_normalize: iterative post-add normalizer for the single-precision adder.
// Takes the raw signed-magnitude sum and the tentative exponent. Shifts the
// mantissa one bit per cycle until the hidden bit sits at bit 25. Presents the
// result in shift/incre form together with a one-cycle valid pulse.
module fp_normalize (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_start,
    input  logic [27:0] i_sum_in,
    input  logic [7:0]  i_exp_in,
    output logic        o_busy,
    output logic        o_valid,
    output logic [27:0] o_shift,
    output logic [8:0]  o_incre,
    output logic        o_underflow
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [26:0] r_mag, w_mag_nxt;
    logic [8:0]  r_e, w_e_nxt;
    logic [8:0]  w_e_inc;
    logic        r_sgn;
    logic        r_uf, w_uf_nxt;
    logic        w_fin;  // NORM has finished; this edge enters DONE

    assign o_busy  = (r_state != S_IDLE);
    assign w_e_inc = r_e + 9'd1;

    // Next-state and datapath: one normalization action per NORM cycle, in priority order
    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_e_nxt     = r_e;
        w_uf_nxt    = r_uf;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mag_nxt   = i_sum_in[26:0];
                    w_e_nxt     = {1'b0, i_exp_in};
                    w_uf_nxt    = 1'b0;
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (r_e[7:0] == 8'hFF) begin
                    // Special/overflow input: flag it, mantissa untouched
                    w_e_nxt = {1'b1, r_e[7:0]};
                    w_fin   = 1'b1;
                end else if (r_mag == 27'd0) begin
                    // Exact zero; the sign register is left alone
                    w_e_nxt = 9'd0;
                    w_fin   = 1'b1;
                end else if (r_mag[26]) begin
                    // Carry out of the add: shift right once, fold the lost bit into sticky
                    w_mag_nxt = {1'b0, r_mag[26:2], r_mag[1] | r_mag[0]};
                    w_e_nxt   = {(w_e_inc[7:0] == 8'hFF), w_e_inc[7:0]};
                    w_fin     = 1'b1;
                end else if (r_mag[25]) begin
                    w_fin = 1'b1;
                end else if (r_e[7:0] == 8'd0) begin
                    // Cannot shift further left without wrapping: denormal result
                    w_uf_nxt = 1'b1;
                    w_fin    = 1'b1;
                end else begin
                    w_mag_nxt = {r_mag[25:0], 1'b0};
                    w_e_nxt   = r_e - 9'd1;
                end
                if (w_fin)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;  // start seen here is dropped, not queued
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and working registers
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            r_state <= S_IDLE;
            r_mag   <= '0;
            r_e     <= '0;
            r_sgn   <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_e     <= w_e_nxt;
            r_uf    <= w_uf_nxt;
            if (r_state == S_IDLE && i_start)
                r_sgn <= i_sum_in[27];
        end
    end

    // Result registers: captured on the edge entering DONE so they are valid during the DONE cycle
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            o_valid     <= 1'b0;
            o_shift     <= '0;
            o_incre     <= '0;
            o_underflow <= 1'b0;
        end else begin
            o_valid <= w_fin;
            if (w_fin) begin
                o_shift     <= {r_sgn, w_mag_nxt};
                o_incre     <= w_e_nxt;
                o_underflow <= w_uf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: directed vectors push expected results,
// a negedge monitor pops and compares whenever valid is seen.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [27:0] sum_in = '0;
    logic [7:0]  exp_in = '0;
    logic        busy, valid, uf;
    logic [27:0] shift;
    logic [8:0]  incre;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic chk_rst = 1'b0;
    logic chk_end = 1'b0;

    typedef struct {
        logic [27:0] sh;
        logic [8:0]  inc;
        logic        uf;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q[$];

    fp_normalize dut (
        .i_clk(clk), .i_res(rst_n), .i_start(start), .i_sum_in(sum_in),
        .i_exp_in(exp_in), .o_busy(busy), .o_valid(valid), .o_shift(shift),
        .o_incre(incre), .o_underflow(uf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons happen here
    always @(negedge clk) begin
        exp_t it;
        if (chk_rst)
            chk("reset_outputs", {busy, valid, uf, incre, shift}, 32'd0);
        if (chk_end)
            chk("queue_drained", q.size(), 0);
        if (valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                it = q.pop_front();
                chk("shift", {4'd0, shift}, {4'd0, it.sh});
                chk("incre", {23'd0, incre}, {23'd0, it.inc});
                chk("underflow", {31'd0, uf}, {31'd0, it.uf});
                chk("latency", cyc - it.t0, it.lat);
            end
        end else if (q.size() != 0 && (cyc - q[0].t0) > 60) begin
            chk("valid_timeout", 1, 0);
            void'(q.pop_front());
        end
    end

    task automatic run(input logic [27:0] s, input logic [7:0] e, input logic [27:0] xs,
                       input logic [8:0] xi, input logic xu, input int lat);
        exp_t it;
        @(posedge clk) #1;
        it.sh = xs; it.inc = xi; it.uf = xu; it.lat = lat; it.t0 = cyc;
        q.push_back(it);
        start = 1'b1; sum_in = s; exp_in = e;
        @(posedge clk) #1;
        start = 1'b0;
        for (int k = 0; k < 80 && q.size() != 0; k++) @(posedge clk);
    endtask

    initial begin
        exp_t it;
        // Reset state
        chk_rst = 1'b1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        chk_rst = 1'b0;
        rst_n = 1'b1;

        run(28'h2000004, 8'h80, 28'h2000004, 9'h080, 1'b0, 2);   // already normal
        run(28'hA000004, 8'h80, 28'hA000004, 9'h080, 1'b0, 2);   // negative, normal
        run(28'h4000003, 8'h7F, 28'h2000001, 9'h080, 1'b0, 2);   // carry, sticky kept
        run(28'h4000002, 8'h10, 28'h2000001, 9'h011, 1'b0, 2);   // carry, guard folds into sticky
        run(28'h4000003, 8'hFE, 28'h2000001, 9'h1FF, 1'b0, 2);   // carry into overflow
        run(28'h1000000, 8'h10, 28'h2000000, 9'h00F, 1'b0, 3);   // one left shift
        run(28'h0000001, 8'h80, 28'h2000000, 9'h067, 1'b0, 27);  // 25 left shifts
        run(28'h0000100, 8'h03, 28'h0000800, 9'h000, 1'b1, 5);   // underflow after 3 shifts
        run(28'h0000010, 8'h00, 28'h0000010, 9'h000, 1'b1, 2);   // underflow with e=0
        run(28'h8000000, 8'h40, 28'h8000000, 9'h000, 1'b0, 2);   // signed zero
        run(28'h0001234, 8'hFF, 28'h0001234, 9'h1FF, 1'b0, 2);   // special exponent

        // Extra starts while busy and during the valid cycle are ignored
        @(posedge clk) #1;
        it.sh = 28'h0000800; it.inc = 9'h000; it.uf = 1'b1; it.lat = 5; it.t0 = cyc;
        q.push_back(it);
        start = 1'b1; sum_in = 28'h0000100; exp_in = 8'h03;
        @(posedge clk) #1; start = 1'b0;                                      // after T0
        @(posedge clk) #1; start = 1'b1; sum_in = 28'h2000000; exp_in = 8'h20; // after T1, busy
        @(posedge clk) #1; start = 1'b0;                                      // after T2
        @(posedge clk) #1;                                                    // after T3
        @(posedge clk) #1; start = 1'b1;                                      // after T4, DONE/valid
        @(posedge clk) #1; start = 1'b0;                                      // after T5
        repeat (10) @(posedge clk);

        // Reset in the middle of a left-shift run: outputs clear, no valid follows
        @(posedge clk) #1;
        start = 1'b1; sum_in = 28'h0000001; exp_in = 8'h80;
        @(posedge clk) #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk_rst = 1'b1;
        @(posedge clk) #1;
        chk_rst = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // Normal operation after reset
        run(28'h2000004, 8'h80, 28'h2000004, 9'h080, 1'b0, 2);

        @(posedge clk) #1;
        chk_end = 1'b1;
        @(posedge clk) #1;
        chk_end = 1'b0;
        @(posedge clk) #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
